quadrature_generator: RTL
=========================

// Module: quadrature_generator
// PURPOSE
//  Synthesises A/B quadrature signals from a commanded signed count and quarter-phase period.
//  Each count is one full 4-state Gray cycle. The encoding matches the pitch decoder:
//  +1 on A rising while B=1, -1 on A rising while B=0.
//  Used for hardware-in-the-loop encoder emulation and decoder self-test on the same fabric.
// PARAMETERS
//  DATA_WIDTH     32   width of cmd_steps and pos_out
//  DIV_WIDTH      16   width of cmd_div (clocks per quarter-phase)
//  INDEX_PERIOD   1024 counts per index revolution (used only with QGEN_INDEX_EN)
// PORTS
//  clk         in   1           single system clock, all logic on posedge
//  rst         in   1           synchronous, active-high reset
//  cmd_valid   in   1           command offered
//  cmd_ready   out  1           high in IDLE; transfer when cmd_valid & cmd_ready
//  cmd_steps   in   DATA_WIDTH  signed count to emit; sign gives direction
//  cmd_div     in   DIV_WIDTH   clocks per quarter-phase; 0 treated as 1
//  abort       in   1           finish current count, then stop
//  output_A    out  1           quadrature A, registered
//  output_B    out  1           quadrature B, registered
//  busy        out  1           high in RUN
//  done        out  1           1-cycle pulse at command completion or abort
//  pos_out     out  DATA_WIDTH  expected decoder count, wraps mod 2^DATA_WIDTH
//  output_Z    out  1           index pulse (only with QGEN_INDEX_EN)
// BEHAVIOUR
//  Reset values: A=B=0, Z=0, pos_out=0, busy=0, done=0, cmd_ready=1, state IDLE.
//  Phase (A,B):
//   - idle/rest phase is always 00
//   - forward:  00->01->11->10->00 (A rises at 01->11, B=1)
//   - reverse:  00->10->11->01->00 (A rises at 00->10, B=0)
//  FSM states: IDLE, RUN.
//  IDLE:
//   - Accept at cycle t.
//   - cmd_steps==0: done=1 at t+1, stay IDLE.
//   - Otherwise latch dir=sign(cmd_steps), remaining=|cmd_steps| as unsigned
//     (-2^(W-1) gives 2^(W-1)), and div=max(cmd_div,1); go RUN.
//  RUN:
//   - Every phase step, including the first at t+div, lasts exactly div clocks.
//   - One count takes 4*div clocks.
//   - On return to 00: remaining-1; pos_out+1 (fwd) or -1 (rev), wrapping.
//   - Stop when remaining hits 0 or abort is pending. In that cycle: done=1,
//     state IDLE, cmd_ready=1.
//   - Back-to-back command accepted on the done cycle: rest phase 00 lasts div clocks.
//  Handshake and cmd_div:
//   - cmd_ready=0 throughout RUN; cmd_valid ignored.
//   - cmd_div changes during RUN have no effect.
//  abort:
//   - Any RUN cycle with abort=1 sets a pending flag.
//   - No partial cycles: A/B always end at 00, and pos_out equals net counts emitted.
//   - abort in IDLE is ignored; the pending flag clears on entering IDLE.
//  Reset mid-RUN: next cycle A=B=0 and pos_out=0. The pending command is discarded with no done.
//  Only one output changes per phase step (Gray): no A/B simultaneous toggles, ever.
// CONFIGURATION
//  QGEN_INDEX_EN defined:
//   - idx counter 0..INDEX_PERIOD-1 tracks counts: +1 fwd wrapping to 0, -1 rev wrapping to max.
//   - When a count completes and idx becomes 0, output_Z=1 for exactly div clocks
//     (the following rest/first quarter).
//   - idx resets to 0.
//  QGEN_INDEX_EN undefined: output_Z tied 0; no idx counter logic.
// STRUCTURE
//  Package quadrature_pkg:
//   - phase encodings PH_00, PH_01, PH_11, PH_10
//   - next-phase function (phase, dir)
//   - FSM state typedef {IDLE, RUN}
//   - shared DATA_WIDTH default for use by the decoder
//  Sub-module quadrature_phase_timer (DIV_WIDTH):
//   - load/div in, one-cycle step strobe every div clocks while enabled
//   - restarts on load
//  Top holds the FSM, phase register, remaining/pos_out counters, abort flag and idx.
// TESTING
//  Scoreboard: in all tests, the decoder instance on A/B matches pos_out at every done.
//  1. steps=+3, div=2:
//     - A/B sequence 01,11,10,00 x3
//     - each phase 2 clks; first edge at t+2; done at t+24; pos_out=3
//  2. steps=-2, div=1:
//     - sequence 10,11,01,00 x2; done at t+8; pos_out=-2 (0xFFFFFFFE)
//  3. steps=+5, div=3, abort pulsed at t+7:
//     - completes count 1 only; done at t+12; pos_out=1; A=B=0
//  4. steps=0:
//     - done at t+1, no A/B activity
//  5. cmd_div=0:
//     - behaves as div=1
//  6. Back-to-back: +1 then -1 offered on the done cycle:
//     - rest 00 for div clks; final pos_out=0
//  7. rst asserted mid-RUN:
//     - A/B/pos_out = 0 next cycle, no done
//     - cmd_ready=1 and a new command accepted after release
//  8. QGEN_INDEX_EN, INDEX_PERIOD=4, steps=+5, div=1:
//     - output_Z high 1 clk after count 4 completes, only once

Source files
------------

// File: rtl/quadrature_pkg.sv
// Shared types for the quadrature generator and its matching pitch decoder.
// Holds the {A,B} phase encodings, the FSM state type and the phase sequencer.
package quadrature_pkg;

  localparam int QGEN_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    PH_00 = 2'b00,
    PH_01 = 2'b01,
    PH_11 = 2'b11,
    PH_10 = 2'b10
  } phase_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Bit 1 is A, bit 0 is B. Forward walks 00->01->11->10, reverse walks it backwards,
  // so A rises with B=1 going forward and with B=0 going in reverse.
  function automatic phase_t next_phase(input phase_t ph, input logic rev);
    phase_t nxt;
    case (ph)
      PH_00:   nxt = rev ? PH_10 : PH_01;
      PH_01:   nxt = rev ? PH_00 : PH_11;
      PH_11:   nxt = rev ? PH_01 : PH_10;
      default: nxt = rev ? PH_11 : PH_00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quadrature_phase_timer.sv
// Quarter-phase timer: strobes o_step on the last clock of every div-clock phase.
// A load restarts the count, treating the load cycle itself as clock 0 of the rest phase.
module quadrature_phase_timer #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic [DIV_WIDTH-1:0] i_div,
  input  logic                 i_en,
  output logic                 o_step,
  output logic [DIV_WIDTH-1:0] o_div
);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] w_cnt_cur;
  logic [DIV_WIDTH-1:0] w_div_cur;
  logic                 w_active;

  // The step decision in the load cycle uses the incoming divider, so div=1 steps at once.
  assign w_active  = i_load || i_en;
  assign w_cnt_cur = i_load ? '0 : r_cnt;
  assign w_div_cur = i_load ? i_div : r_div;
  assign o_step    = w_active && (w_cnt_cur == (w_div_cur - DIV_WIDTH'(1)));
  assign o_div     = r_div;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_div <= DIV_WIDTH'(1);
    end else begin
      if (i_load) begin
        r_div <= i_div;
      end
      if (o_step) begin
        r_cnt <= '0;
      end else if (w_active) begin
        r_cnt <= w_cnt_cur + DIV_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/quadrature_generator.sv
// A/B quadrature synthesiser: emits a signed number of full Gray cycles at div clocks per quarter.
// Optional index pulse output_Z is built only when QGEN_INDEX_EN is defined.
module quadrature_generator
  import quadrature_pkg::*;
#(
  parameter int DATA_WIDTH   = QGEN_DATA_WIDTH,
  parameter int DIV_WIDTH    = 16,
  parameter int INDEX_PERIOD = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic signed [DATA_WIDTH-1:0] cmd_steps,
  input  logic        [DIV_WIDTH-1:0]  cmd_div,
  input  logic                         abort,
  output logic                         output_A,
  output logic                         output_B,
  output logic                         busy,
  output logic                         done,
  output logic        [DATA_WIDTH-1:0] pos_out,
  output logic                         output_Z
);

  localparam logic [DATA_WIDTH-1:0] ONE_D = DATA_WIDTH'(1);

  state_t                r_state;
  phase_t                r_phase;
  logic                  r_rev;
  logic [DATA_WIDTH-1:0] r_remaining;
  logic [DATA_WIDTH-1:0] r_pos;
  logic                  r_abort_pend;
  logic                  r_done;

  logic                  w_run;
  logic                  w_accept;
  logic                  w_zero_cmd;
  logic                  w_load;
  logic                  w_cmd_rev;
  logic                  w_rev_cur;
  logic                  w_step;
  logic                  w_wrap;
  logic                  w_last;
  logic [DIV_WIDTH-1:0]  w_div_eff;
  logic [DIV_WIDTH-1:0]  w_div_q;
  logic [DATA_WIDTH-1:0] w_steps_u;
  phase_t                w_next_phase;

  function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] d);
    return (d == '0) ? DIV_WIDTH'(1) : d;
  endfunction

  // Two's-complement magnitude; the most negative count maps to 2^(W-1) unsigned.
  function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] v);
    return v[DATA_WIDTH-1] ? (~v + ONE_D) : v;
  endfunction

  assign w_run        = (r_state == RUN);
  assign w_accept     = cmd_valid && !w_run;
  assign w_zero_cmd   = (cmd_steps == '0);
  assign w_load       = w_accept && !w_zero_cmd;
  assign w_cmd_rev    = cmd_steps[DATA_WIDTH-1];
  assign w_steps_u    = cmd_steps;
  assign w_div_eff    = clamp_div(cmd_div);
  assign w_rev_cur    = w_run ? r_rev : w_cmd_rev;
  assign w_next_phase = next_phase(r_phase, w_rev_cur);
  assign w_wrap       = w_run && w_step && (w_next_phase == PH_00);
  assign w_last       = w_wrap && ((r_remaining == ONE_D) || r_abort_pend || abort);

  quadrature_phase_timer #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_div  (w_div_eff),
    .i_en   (w_run),
    .o_step (w_step),
    .o_div  (w_div_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_phase      <= PH_00;
      r_rev        <= 1'b0;
      r_pos        <= '0;
      r_abort_pend <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_abort_pend <= 1'b0;
          if (w_accept) begin
            if (w_zero_cmd) begin
              r_done <= 1'b1;
            end else begin
              r_rev       <= w_cmd_rev;
              r_remaining <= magnitude(w_steps_u);
              r_state     <= RUN;
              if (w_step) begin
                r_phase <= w_next_phase;
              end
            end
          end
        end
        default: begin
          if (abort) begin
            r_abort_pend <= 1'b1;
          end
          if (w_step) begin
            r_phase <= w_next_phase;
          end
          // Counts are only retired on the return to 00, so A/B always rest at 00.
          if (w_wrap) begin
            r_remaining <= r_remaining - ONE_D;
            r_pos       <= r_rev ? (r_pos - ONE_D) : (r_pos + ONE_D);
          end
          if (w_last) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign output_A  = r_phase[1];
  assign output_B  = r_phase[0];
  assign busy      = w_run;
  assign cmd_ready = !w_run;
  assign done      = r_done;
  assign pos_out   = r_pos;

`ifdef QGEN_INDEX_EN
  localparam int IDX_W = (INDEX_PERIOD > 1) ? $clog2(INDEX_PERIOD) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(INDEX_PERIOD - 1);

  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     w_idx_next;
  logic                 r_z;
  logic [DIV_WIDTH-1:0] r_z_left;

  assign w_idx_next = r_rev ? ((r_idx == '0) ? IDX_MAX : (r_idx - IDX_W'(1)))
                            : ((r_idx == IDX_MAX) ? '0 : (r_idx + IDX_W'(1)));

  // Z covers the rest quarter that follows the count landing on index 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx    <= '0;
      r_z      <= 1'b0;
      r_z_left <= '0;
    end else begin
      if (r_z) begin
        if (r_z_left == '0) begin
          r_z <= 1'b0;
        end else begin
          r_z_left <= r_z_left - DIV_WIDTH'(1);
        end
      end
      if (w_wrap) begin
        r_idx <= w_idx_next;
        if (w_idx_next == '0) begin
          r_z      <= 1'b1;
          r_z_left <= w_div_q - DIV_WIDTH'(1);
        end
      end
    end
  end

  assign output_Z = r_z;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (^w_div_q) ^ (INDEX_PERIOD > 0);
  assign output_Z     = 1'b0;
`endif

endmodule
